// File: rtl/ping_trigger_pkg.sv
// Shared state encoding and constants for the acoustic ping trigger.
package ping_trigger_pkg;

  localparam int NCH = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ARMED   = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  function automatic int unsigned MIDSCALE(int unsigned dw);
    return 32'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/sample_delay.sv
// Fixed-latency per-channel delay line; DEPTH cycles from din to dout.
module sample_delay #(
  parameter int DW    = 14,
  parameter int DEPTH = 66
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  // No reset on the line itself so it maps onto shift/RAM primitives.
  logic [DW-1:0] line [DEPTH-1];

  always_ff @(posedge clk) begin
    line[0] <= din;
    for (int i = 1; i < DEPTH - 1; i++)
      line[i] <= line[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= line[DEPTH-2];
  end

endmodule

// File: rtl/ping_trigger.sv
// Threshold ping detector gating a pre-triggered record into storage.
module ping_trigger
  import ping_trigger_pkg::*;
#(
  parameter int DW        = 14,
  parameter int PRE_DEPTH = 64,
  parameter int CAP_LEN   = 4096,
  parameter int HOLDOFF   = 16384,
  parameter int MIN_RUN   = 2
) (
  input  logic          wrclk,
  input  logic          _mr,
  input  logic [DW-1:0] dinA,
  input  logic [DW-1:0] dinB,
  input  logic [DW-1:0] dinC,
  input  logic [DW-1:0] dinD,
  input  logic [DW-1:0] thresh,
  input  logic [3:0]    chan_mask,
  input  logic          arm,
  input  logic          force_trig,
  output logic [DW-1:0] doutA,
  output logic [DW-1:0] doutB,
  output logic [DW-1:0] doutC,
  output logic [DW-1:0] doutD,
  output logic          load,
  output logic          triggered,
  output logic [3:0]    trig_chan,
  output logic [2:0]    state_o
);

  localparam int LAT = PRE_DEPTH + 2;
  localparam int FW  = $clog2(LAT + 1);
  localparam int LW  = $clog2(CAP_LEN + 1);
  localparam int HW  = $clog2(HOLDOFF + 1);
  localparam int RW  = $clog2(MIN_RUN + 1);
  localparam logic [DW-1:0] MID = DW'(MIDSCALE(DW));

  // Async assert, release aligned to wrclk.
  logic rst_meta;
  logic rst_n;

  always_ff @(posedge wrclk or negedge _mr) begin
    if (!_mr) {rst_n, rst_meta} <= 2'b00;
    else      {rst_n, rst_meta} <= {rst_meta, 1'b1};
  end

  logic [DW-1:0] din  [NCH];
  logic [DW-1:0] dout [NCH];

  assign din[0] = dinA;
  assign din[1] = dinB;
  assign din[2] = dinC;
  assign din[3] = dinD;

  for (genvar c = 0; c < NCH; c++) begin : g_dly
    sample_delay #(
      .DW   (DW),
      .DEPTH(LAT)
    ) u_dly (
      .clk  (wrclk),
      .rst_n(rst_n),
      .din  (din[c]),
      .dout (dout[c])
    );
  end

  assign doutA = dout[0];
  assign doutB = dout[1];
  assign doutC = dout[2];
  assign doutD = dout[3];

  function automatic logic [DW-1:0] mag_of(logic [DW-1:0] s);
    return (s >= MID) ? s - MID : MID - s;
  endfunction

  logic [NCH-1:0] hit_d;
  logic [NCH-1:0] hit;

  always_comb begin
    hit_d = '0;
    for (int c = 0; c < NCH; c++)
      hit_d[c] = chan_mask[c] && (mag_of(din[c]) > thresh);
  end

  state_t        state;
  state_t        state_nxt;
  logic [FW-1:0] fill_cnt;
  logic [LW-1:0] len_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] run;
  logic [RW-1:0] run_nxt;
  logic          det;
  logic          arm_q;

  always_comb begin
    run_nxt = '0;
    if (|hit)
      run_nxt = (run == RW'(MIN_RUN)) ? run : run + 1'b1;
  end

  assign det = (run_nxt == RW'(MIN_RUN));

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (arm) state_nxt = S_FILL;
      end
      S_FILL: begin
        if (!arm)                          state_nxt = S_IDLE;
        else if (fill_cnt == FW'(LAT - 1)) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!arm)                   state_nxt = S_IDLE;
        else if (det || force_trig) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (len_cnt == LW'(CAP_LEN - 1)) state_nxt = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (hold_cnt == HW'(HOLDOFF - 1))
          state_nxt = arm ? S_ARMED : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hit       <= '0;
      run       <= '0;
      fill_cnt  <= '0;
      len_cnt   <= '0;
      hold_cnt  <= '0;
      arm_q     <= 1'b0;
      triggered <= 1'b0;
      trig_chan <= '0;
    end else begin
      state    <= state_nxt;
      hit      <= hit_d;
      arm_q    <= arm;
      run      <= (state == S_ARMED) ? run_nxt : '0;
      // Each counter restarts from zero whenever its state is entered.
      fill_cnt <= (state == S_FILL && state_nxt == S_FILL)
                  ? fill_cnt + 1'b1 : '0;
      len_cnt  <= (state == S_CAPTURE && state_nxt == S_CAPTURE)
                  ? len_cnt + 1'b1 : '0;
      hold_cnt <= (state == S_HOLDOFF && state_nxt == S_HOLDOFF)
                  ? hold_cnt + 1'b1 : '0;
      if (state == S_ARMED && state_nxt == S_CAPTURE) begin
        triggered <= 1'b1;
        trig_chan <= det ? hit : '0;
      end else if (arm && !arm_q) begin
        triggered <= 1'b0;
      end
    end
  end

  assign load    = (state == S_CAPTURE);
  assign state_o = state;

endmodule

// File: doc/ping_trigger.md
# ping_trigger

Acoustic ping detector between the ADC capture stage and the storage FIFO stage, clocked by the capture clock (`data_clk`). Four 14-bit offset-binary channels pass through a fixed pre-trigger delay line. Each channel's magnitude about midscale is compared against a programmable threshold. On a qualified ping, the block drives `load` for exactly one record length, so storage receives pre-trigger samples followed by the ping.

## Interface
Parameters:
- `DW`, 14, sample width (offset binary)
- `PRE_DEPTH`, 64, pre-trigger samples per record (≥2)
- `CAP_LEN`, 4096, cycles `load` is held high per record
- `HOLDOFF`, 16384, dead cycles after a record before re-arming
- `MIN_RUN`, 2, consecutive over-threshold samples required (≥1)

Ports:
- `wrclk`  in  1  sample clock; one sample per cycle on every channel
- `_mr`  in  1  active-low master reset; asynchronous assert, synchronous deassert in this domain
- `dinA`..`dinD`  in  DW each  samples from capture
- `thresh`  in  DW  unsigned magnitude threshold, compared strictly greater-than
- `chan_mask`  in  4  per-channel detect enable; bit0 = A
- `arm`  in  1  level; detector armed while high
- `force`  in  1  software trigger, single-cycle pulse
- `doutA`..`doutD`  out  DW each  delayed samples to storage
- `load`  out  1  storage write window
- `triggered`  out  1  sticky; set on trigger, cleared on `arm` rising edge
- `trig_chan`  out  4  channels over threshold on the triggering sample; 0 on forced trigger
- `state_o`  out  3  current state encoding, used for LEDs and debug

## Operation
- Magnitude: `mag = |din − 2^(DW−1)|`, DW-bit unsigned. Input 0 gives 8192 and is not saturated. `hit[c] = chan_mask[c] && mag[c] > thresh`.
- Run counter: increments when any bit of `hit` is set and clears otherwise. It saturates at `MIN_RUN`. It is cleared in every state except ARMED.
- States:
  - IDLE (0): `arm` high → FILL. The fill counter is cleared on entry.
  - FILL (1): counts `PRE_DEPTH` + 2 cycles so the delay line holds valid data, then → ARMED. `arm` low → IDLE.
  - ARMED (2): the run reaching `MIN_RUN`, or `force` high, → CAPTURE. The same edge latches `trig_chan` (current `hit`, or 0 when forced), sets `triggered`, and loads the length counter. `arm` low → IDLE. A detector trigger and `force` in the same cycle count as a detector trigger.
  - CAPTURE (3): `load` = 1 for exactly `CAP_LEN` cycles, then → HOLDOFF. Deasserting `arm` does not truncate the record.
  - HOLDOFF (4): `load` = 0 for `HOLDOFF` cycles. Then → ARMED if `arm` is high (no refill; the line is still valid), else → IDLE.
- `force` is ignored outside ARMED. `thresh` and `chan_mask` are sampled every cycle with no shadowing.
- Reset (including mid-CAPTURE): state IDLE; `load`, `triggered`, `trig_chan`, `state_o`, all counters and all `dout*` = 0; delay-line contents are don't-care. `load` drops asynchronously with `_mr`.

## Timing
- `din` → `dout` latency: exactly `PRE_DEPTH` + 2 cycles on all channels, fixed in all states.
- A sample on `din` at cycle t that completes the run gives `hit` registered at t+1 and `load` = 1 from t+2 through t+1+`CAP_LEN`.
- The first loaded `dout` equals `din` at cycle t − `PRE_DEPTH`. The triggering sample is therefore loaded sample index `PRE_DEPTH` (0-based).
- Forced trigger: `force` high at cycle f gives `load` = 1 from f+1, with identical alignment relative to f.
- Counters are `$clog2(max+1)` bits wide. No wrap is possible; all terminal counts are compared for equality.

## Structure
- Package `ping_trigger_pkg`: state enum (5 values, 3-bit encoding as listed above), `MIDSCALE` function of `DW`, channel count constant 4.
- Sub-module `sample_delay` (DW, DEPTH): per-channel fixed delay line, inferred as SRL/BRAM, instantiated ×4. All FSM, magnitude and counter logic stays in the top module.

## Test plan
- Reset: `_mr` low mid-CAPTURE → `load` = 0 immediately; after release, `state_o` = 0 and `dout*` = 0 until data propagates.
- Threshold edge: `thresh` = 1000, `dinB` = 9192 (mag 1000) held → no trigger. Then `dinB` = 9193 for 2 cycles → `load` rises 2 cycles after the second sample, `trig_chan` = 4'b0010, and the first `dout` is the sample 64 earlier.
- `MIN_RUN` = 2: single-cycle spikes alternating with midscale → never triggers. Masked channel C over threshold with `chan_mask` = 4'b1011 → no trigger.
- `force` pulse in ARMED with all channels at midscale → `load` for exactly 4096 cycles, `trig_chan` = 0; `force` in FILL → ignored.
- `arm` dropped during CAPTURE → full 4096-cycle record, then HOLDOFF → IDLE. `arm` held → ARMED after 16384 cycles, and a second ping triggers without a refill.
- Simultaneous hit and `force` → `trig_chan` shows the hit channels. Input 0 on channel A with `thresh` = 8191 → triggers (mag 8192).
